// File: rtl/can_bit_stuffer.sv
// CAN transmit bit stuffer: inserts a complementary bit after
// RUN_LEN equal bits and holds the frame sequencer meanwhile.
module can_bit_stuffer #(
  parameter int RUN_LEN = 5,
  parameter int CNT_W   = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             baud_tick,
  input  logic             bit_in,
  input  logic             stuff_en,
  input  logic             txing,
  output logic             bitstuffed_output,
  output logic             hold,
  output logic             stuff_slot,
  output logic [CNT_W-1:0] stuff_total
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PASS  = 2'd1;
  localparam logic [1:0] STUFF = 2'd2;

  localparam logic [3:0] RUN_MAX = 4'(RUN_LEN);

  logic [1:0] state;
  logic [3:0] run;
  logic       last;
  logic [3:0] run_nxt;
  logic       run_full;

  // Length of the run once the current bit_in joins it.
  always_comb begin
    run_nxt = 4'd1;
    if (stuff_en && (bit_in == last))
      run_nxt = run + 4'd1;
    run_full = stuff_en && (run_nxt == RUN_MAX);
  end

  // Line bit, run tracking and stuff insertion, one step per baud tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      run               <= 4'd0;
      last              <= 1'b1;
      bitstuffed_output <= 1'b1;
      hold              <= 1'b0;
      stuff_slot        <= 1'b0;
      stuff_total       <= '0;
    end else if (baud_tick) begin
      if (!txing) begin
        state             <= IDLE;
        run               <= 4'd0;
        last              <= 1'b1;
        bitstuffed_output <= 1'b1;
        hold              <= 1'b0;
        stuff_slot        <= 1'b0;
      end else if (state == STUFF) begin
        bitstuffed_output <= ~last;
        last              <= ~last;
        run               <= 4'd1;
        stuff_slot        <= 1'b1;
        hold              <= 1'b0;
        state             <= PASS;
        if (!(&stuff_total))
          stuff_total <= stuff_total + 1'b1;
      end else begin
        if (state == IDLE)
          stuff_total <= '0;
        bitstuffed_output <= bit_in;
        stuff_slot        <= 1'b0;
        last              <= bit_in;
        run               <= run_nxt;
        hold              <= run_full;
        state             <= run_full ? STUFF : PASS;
      end
    end
  end

endmodule

// File: tb/tb_can_bit_stuffer.sv
// Bench for can_bit_stuffer: directed vector table, corner
// sequences and random frames against a stream-level model.
module tb_can_bit_stuffer;

  localparam int RUN_LEN = 5;
  localparam int CNT_W   = 7;

  logic             clk = 1'b0;
  logic             rst;
  logic             baud_tick;
  logic             bit_in;
  logic             stuff_en;
  logic             txing;
  logic             bitstuffed_output;
  logic             hold;
  logic             stuff_slot;
  logic [CNT_W-1:0] stuff_total;

  can_bit_stuffer #(.RUN_LEN(RUN_LEN), .CNT_W(CNT_W)) dut (
    .clk               (clk),
    .rst               (rst),
    .baud_tick         (baud_tick),
    .bit_in            (bit_in),
    .stuff_en          (stuff_en),
    .txing             (txing),
    .bitstuffed_output (bitstuffed_output),
    .hold              (hold),
    .stuff_slot        (stuff_slot),
    .stuff_total       (stuff_total)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       tx;
    logic       se;
    logic       b;
    logic       line;
    logic       hld;
    logic       slot;
    logic [6:0] total;
  } vec_t;

  typedef struct {
    logic b;
    logic se;
  } fbit_t;

  typedef struct {
    logic line;
    logic slot;
    logic hld;
  } obit_t;

  vec_t  tbl[$];
  fbit_t frame[$];
  obit_t exp_q[$];
  int    exp_stuffs;
  int    n_vec  = 0;
  int    n_errs = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic l, input logic h,
                         input logic s, input int tot);
    chk({tag, " line"}, int'(bitstuffed_output), int'(l));
    chk({tag, " hold"}, int'(hold), int'(h));
    chk({tag, " slot"}, int'(stuff_slot), int'(s));
    chk({tag, " total"}, int'(stuff_total), tot);
  endtask

  function automatic void add(input logic tx, input logic se, input logic b,
                              input logic l, input logic h, input logic s,
                              input int tot);
    vec_t v;
    v.tx = tx; v.se = se; v.b = b;
    v.line = l; v.hld = h; v.slot = s; v.total = 7'(tot);
    tbl.push_back(v);
  endfunction

  // Expected line stream: every frame bit appears once, and a
  // complement follows whenever RUN_LEN equal bits have accumulated
  // counting from the last unstuffed bit or stuff bit.
  task automatic build_model();
    int   run;
    logic last;
    obit_t o;
    run = 0;
    last = 1'b1;
    exp_q.delete();
    exp_stuffs = 0;
    foreach (frame[i]) begin
      if (!frame[i].se) run = 1;
      else if (frame[i].b == last) run = run + 1;
      else run = 1;
      last = frame[i].b;
      o.line = frame[i].b;
      o.slot = 1'b0;
      o.hld = frame[i].se && (run == RUN_LEN);
      exp_q.push_back(o);
      if (o.hld) begin
        o.line = ~last;
        o.slot = 1'b1;
        o.hld = 1'b0;
        exp_q.push_back(o);
        last = ~last;
        run = 1;
        exp_stuffs++;
      end
    end
  endtask

  // Acts as the frame sequencer: advances its bit pointer only on
  // ticks where hold was low, then closes the frame with txing low.
  task automatic run_frame(input string tag, input bit gaps);
    int   ptr;
    int   idx;
    int   sat;
    logic h;
    build_model();
    ptr = 0;
    idx = 0;
    while (idx < exp_q.size()) begin
      txing = 1'b1;
      if (ptr < frame.size()) begin
        bit_in = frame[ptr].b;
        stuff_en = frame[ptr].se;
      end else begin
        bit_in = 1'b1;
        stuff_en = 1'b0;
      end
      h = hold;
      baud_tick = 1'b1;
      @(posedge clk); #1;
      baud_tick = 1'b0;
      chk({tag, " line"}, int'(bitstuffed_output), int'(exp_q[idx].line));
      chk({tag, " slot"}, int'(stuff_slot), int'(exp_q[idx].slot));
      chk({tag, " hold"}, int'(hold), int'(exp_q[idx].hld));
      idx++;
      if (!h) ptr++;
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          bit_in = 1'($urandom);
          stuff_en = 1'($urandom);
          @(posedge clk); #1;
          chk({tag, " gap line"}, int'(bitstuffed_output),
              int'(exp_q[idx-1].line));
          chk({tag, " gap hold"}, int'(hold), int'(exp_q[idx-1].hld));
        end
      end
    end
    chk({tag, " consumed"}, ptr, frame.size());
    sat = (exp_stuffs > 127) ? 127 : exp_stuffs;
    chk({tag, " total"}, int'(stuff_total), sat);
    txing = 1'b0;
    baud_tick = 1'b1;
    @(posedge clk); #1;
    baud_tick = 1'b0;
    chk_out({tag, " idle"}, 1'b1, 1'b0, 1'b0, sat);
  endtask

  function automatic void push_bit(input logic b, input logic se);
    fbit_t f;
    f.b = b;
    f.se = se;
    frame.push_back(f);
  endfunction

  task automatic tick(input logic tx, input logic se, input logic b);
    txing = tx;
    stuff_en = se;
    bit_in = b;
    baud_tick = 1'b1;
    @(posedge clk); #1;
    baud_tick = 1'b0;
  endtask

  initial begin
    logic prev;
    rst = 1'b1;
    baud_tick = 1'b0;
    bit_in = 1'b0;
    stuff_en = 1'b0;
    txing = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", 1'b1, 1'b0, 1'b0, 0);
    rst = 1'b0;

    // plain echo, no stuffing
    add(0, 0, 0, 1, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0);
    add(1, 1, 1, 1, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 0);
    add(1, 1, 1, 1, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0);
    // SOF plus four stuffed zeros forces a one
    add(1, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 1, 0, 0);
    add(1, 1, 1, 1, 0, 1, 1);
    add(1, 1, 1, 1, 0, 0, 1);
    add(0, 0, 0, 1, 0, 0, 1);
    // new frame clears the count; abort while hold pending
    add(1, 0, 1, 1, 0, 0, 0);
    add(1, 1, 1, 1, 0, 0, 0);
    add(1, 1, 1, 1, 0, 0, 0);
    add(1, 1, 1, 1, 0, 0, 0);
    add(1, 1, 1, 1, 1, 0, 0);
    add(0, 1, 1, 1, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 1, 0, 0);
    add(1, 0, 1, 1, 0, 1, 1);
    add(0, 0, 0, 1, 0, 0, 1);

    foreach (tbl[i]) begin
      tick(tbl[i].tx, tbl[i].se, tbl[i].b);
      chk_out($sformatf("vec%0d", i), tbl[i].line, tbl[i].hld,
              tbl[i].slot, int'(tbl[i].total));
    end

    // eleven stuffed ones after SOF
    frame.delete();
    push_bit(0, 0);
    repeat (11) push_bit(1, 1);
    repeat (3) push_bit(1, 0);
    run_frame("ones11", 1'b0);
    chk("ones11 stuffs", int'(stuff_total), 2);

    // stuff bit still emitted after stuff_en drops
    frame.delete();
    push_bit(0, 0);
    repeat (5) push_bit(1, 1);
    repeat (3) push_bit(1, 0);
    run_frame("crc_end", 1'b0);
    chk("crc_end line len", exp_q.size(), 10);
    chk("crc_end stuff bit", int'(exp_q[6].line), 0);

    // async reset between edges, mid-frame with a stuff counted
    tick(1, 0, 0);
    repeat (4) tick(1, 1, 0);
    tick(1, 1, 1);
    tick(1, 1, 1);
    tick(1, 1, 0);
    chk_out("pre_rst", 1'b0, 1'b0, 1'b0, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_out("async_rst", 1'b1, 1'b0, 1'b0, 0);
    #1;
    rst = 1'b0;
    frame.delete();
    repeat (6) push_bit(0, 1);
    repeat (3) push_bit(1, 0);
    run_frame("post_rst", 1'b0);

    // saturation of the stuff counter
    frame.delete();
    push_bit(0, 0);
    repeat (720) push_bit(0, 1);
    repeat (3) push_bit(1, 0);
    run_frame("saturate", 1'b0);

    // random frames with baud gaps
    for (int f = 0; f < 40; f++) begin
      frame.delete();
      push_bit(0, 0);
      prev = 1'b0;
      for (int k = 0; k < $urandom_range(10, 80); k++) begin
        if ($urandom_range(0, 9) < 7) prev = prev;
        else prev = ~prev;
        push_bit(prev, ($urandom_range(0, 15) != 0));
      end
      repeat ($urandom_range(1, 3)) push_bit(1, 0);
      run_frame($sformatf("rnd%0d", f), 1'b1);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_errs);
    $finish;
  end

endmodule
